filter: RTL and testbench

FILTER -- requirements
Module: filter

---
 rtl/filter.sv | 102 ++++++++++
 tb/tb_filter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/filter.sv
// Edge-preserving two-pixel blend filter.
// Blends current pixel a with neighbour b using a weight that rises from a
// plain average (flat regions) to a pass-through of a (strong edges).
// Two-stage pipeline: stage 1 captures pixels and weight, stage 2 blends.
// Optional feature macro: FILTER_ROUND_EN selects round-half-up on c_i;
// without it c_i is truncated. result is identical in both builds.
// Note: rst_n is an active-high asynchronous reset despite its name.
module filter #(
  parameter int N         = 8,
  parameter int T_LO      = 16,
  parameter int SPAN_LOG2 = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           act,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] result,
  output logic [N-1:0]   c_i
);

  // Upper end of the transition band; may equal 2^N, so compare in N+1 bits.
  localparam int T_HI  = T_LO + (1 << SPAN_LOG2);
  localparam int SHIFT = N - 1 - SPAN_LOG2;

  localparam logic [N:0] K_HALF = {2'b01, {(N-1){1'b0}}};
  localparam logic [N:0] K_FULL = {1'b1, {N{1'b0}}};
  localparam logic [N:0] T_LO_K = (N+1)'(T_LO);
  localparam logic [N:0] T_HI_K = (N+1)'(T_HI);

  logic [N-1:0]   d;
  logic [N:0]     d_ext;
  logic [N:0]     offset;
  logic [N:0]     k;

  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N:0]     k_q;
  logic           v1;

  logic [2*N-1:0] blend;
  logic           round_bit;
  logic [N:0]     ci_wide;
  logic [N-1:0]   ci_next;

  // Absolute difference and weight selection from the live inputs.
  always_comb begin
    d      = (a >= b) ? (a - b) : (b - a);
    d_ext  = {1'b0, d};
    offset = d_ext - T_LO_K;
    k      = K_HALF;
    if (d_ext < T_LO_K) begin
      k = K_HALF;
    end else if (d_ext >= T_HI_K) begin
      k = K_FULL;
    end else begin
      k = K_HALF + (offset << SHIFT);
    end
  end

  // Stage 1: capture pixels and weight on qualified samples; valid tracks act.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= act;
      if (act) begin
        a_q <= a;
        b_q <= b;
        k_q <= k;
      end
    end
  end

  // Weighted sum and output pixel from stage-1 data; each product fits 2N bits
  // because a weight of 2^N on one side forces 0 on the other.
  always_comb begin
    blend = ((2*N)'(a_q) * (2*N)'(k_q)) + ((2*N)'(b_q) * (2*N)'(K_FULL - k_q));
`ifdef FILTER_ROUND_EN
    round_bit = blend[N-1];
`else
    round_bit = 1'b0;
`endif
    ci_wide = {1'b0, blend[2*N-1:N]} + (N+1)'(round_bit);
    ci_next = ci_wide[N] ? {N{1'b1}} : ci_wide[N-1:0];
  end

  // Stage 2: update outputs only when a valid sample sits in stage 1.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      result <= '0;
      c_i    <= '0;
    end else if (v1) begin
      result <= blend;
      c_i    <= ci_next;
    end
  end

endmodule

// File: tb/tb_filter.sv
// Directed, table-driven testbench for filter (default parameters).
module tb_filter;

  logic        clk;
  logic        rst_n;
  logic        act;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] result;
  logic [7:0]  c_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_result;
    logic [7:0]  exp_ci_trunc;
    logic [7:0]  exp_ci_round;
  } vec_t;

  vec_t vecs[9];

  filter #(.N(8), .T_LO(16), .SPAN_LOG2(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .act    (act),
    .a      (a),
    .b      (b),
    .result (result),
    .c_i    (c_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs across one rising edge; returns on the following falling edge.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vact);
    a   = va;
    b   = vb;
    act = vact;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp_r, input logic [7:0] exp_c);
    checks++;
    if (result !== exp_r) begin
      errors++;
      $display("[TB] FAIL %s result: got %0d expected %0d", name, result, exp_r);
    end
    checks++;
    if (c_i !== exp_c) begin
      errors++;
      $display("[TB] FAIL %s c_i: got %0d expected %0d", name, c_i, exp_c);
    end
  endtask

  function automatic logic [7:0] pickCi(input logic [7:0] t, input logic [7:0] r);
`ifdef FILTER_ROUND_EN
    return r;
`else
    return t;
`endif
  endfunction

  initial begin
    vecs[0] = '{8'd255, 8'd50,  16'd65280, 8'd255, 8'd255};
    vecs[1] = '{8'd30,  8'd70,  16'd10880, 8'd42,  8'd43};
    vecs[2] = '{8'd100, 8'd110, 16'd26880, 8'd105, 8'd105};
    vecs[3] = '{8'd50,  8'd255, 16'd12800, 8'd50,  8'd50};
    vecs[4] = '{8'd70,  8'd30,  16'd14720, 8'd57,  8'd58};
    vecs[5] = '{8'd15,  8'd0,   16'd1920,  8'd7,   8'd8};
    vecs[6] = '{8'd255, 8'd255, 16'd65280, 8'd255, 8'd255};
    vecs[7] = '{8'd0,   8'd0,   16'd0,     8'd0,   8'd0};
    vecs[8] = '{8'd16,  8'd0,   16'd2048,  8'd8,   8'd8};

    rst_n = 1'b1;
    act   = 1'b0;
    a     = 8'd0;
    b     = 8'd0;

    // Reset held with act toggling and live data: outputs must stay zero.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'($urandom_range(255)), 8'($urandom_range(255)), 1'(i % 2 == 0));
      checkOutput($sformatf("reset%0d", i), 16'd0, 8'd0);
    end
    rst_n = 1'b0;
    applyStimulus(8'd0, 8'd0, 1'b0);
    checkOutput("post_reset_idle", 16'd0, 8'd0);

    // Single samples: drive one act=1 cycle, outputs valid two edges later.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b1);
      applyStimulus(8'd0, 8'd0, 1'b0);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_result,
                  pickCi(vecs[i].exp_ci_trunc, vecs[i].exp_ci_round));
    end

    // Flat region then five idle cycles with changing inputs: outputs hold.
    applyStimulus(8'd100, 8'd110, 1'b1);
    applyStimulus(8'd0, 8'd0, 1'b0);
    checkOutput("flat", 16'd26880, 8'd105);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b0);
      checkOutput($sformatf("flat_hold%0d", i), 16'd26880, 8'd105);
    end

    // Back-to-back stream across the band boundaries.
    applyStimulus(8'd16, 8'd0, 1'b1);
    applyStimulus(8'd80, 8'd0, 1'b1);
    checkOutput("b2b_dlo", 16'd2048, 8'd8);
    applyStimulus(8'd79, 8'd0, 1'b1);
    checkOutput("b2b_edge", 16'd20480, 8'd80);
    applyStimulus(8'd0, 8'd0, 1'b0);
    checkOutput("b2b_dhi_m1", 16'd20066, 8'd78);
    applyStimulus(8'd0, 8'd0, 1'b0);
    checkOutput("b2b_hold", 16'd20066, 8'd78);

    // Reset mid-flight: the sample in stage 1 must never reach the outputs.
    applyStimulus(8'd200, 8'd0, 1'b1);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_async", 16'd0, 8'd0);
    @(negedge clk);
    checkOutput("midrst_held", 16'd0, 8'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'd0, 8'd0, 1'b0);
      checkOutput($sformatf("midrst_after%0d", i), 16'd0, 8'd0);
    end

    // First sample after reset release appears two edges later.
    applyStimulus(8'd30, 8'd70, 1'b1);
    checkOutput("rel_latency_early", 16'd0, 8'd0);
    applyStimulus(8'd0, 8'd0, 1'b0);
    checkOutput("rel_first", 16'd10880, pickCi(8'd42, 8'd43));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
